// File: rtl/regfile_wb_ctrl.sv
// Write-back arbiter and busy scoreboard for the 32x64 register file.
// Optional RAW forwarding from the registered write port: REGWB_FWD_EN.
module regfile_wb_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            iss_valid,
  input  logic            iss_wen,
  input  logic [4:0]      iss_rd,
  output logic            iss_ready,
  input  logic [4:0]      rs1,
  input  logic [4:0]      rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            a_valid,
  output logic            a_ready,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  input  logic            b_valid,
  output logic            b_ready,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            err_spurious
`ifdef REGWB_FWD_EN
  ,
  output logic            rs1_fwd,
  output logic            rs2_fwd,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic [XLEN-1:0] rs2_fwd_data
`endif
);

  logic [31:0]     busy_q, busy_d;
  logic            pri_q, pri_d;
  logic            rf_wen_q;
  logic [4:0]      rf_waddr_q;
  logic [XLEN-1:0] rf_wdata_q;
  logic            err_q;

  logic            xfer;
  logic [4:0]      x_rd;
  logic [XLEN-1:0] x_data;
  logic            set_en;
  logic            spur;

  // Issue gate and round-robin grants; all held low during reset
  always_comb begin
    iss_ready = rst &&
      (!iss_wen || (iss_rd == 5'd0) || !busy_q[iss_rd]);
    a_ready = rst && a_valid && (!b_valid || !pri_q);
    b_ready = rst && b_valid && (!a_valid || pri_q);
  end

  // Select the granted requester and classify the transfer
  always_comb begin
    xfer   = a_ready || b_ready;
    x_rd   = a_ready ? a_rd : b_rd;
    x_data = a_ready ? a_data : b_data;
    set_en = iss_valid && iss_ready && iss_wen &&
             (iss_rd != 5'd0);
    spur   = xfer && (x_rd != 5'd0) && !busy_q[x_rd] &&
             !(set_en && (iss_rd == x_rd));
  end

  // Scoreboard next state: commit clears, a new producer wins
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q)
      busy_d[rf_waddr_q] = 1'b0;
    if (set_en)
      busy_d[iss_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Pointer moves to the side that lost (or was absent) after a grant
  always_comb begin
    pri_d = pri_q;
    if (a_ready)
      pri_d = 1'b1;
    else if (b_ready)
      pri_d = 1'b0;
  end

  // Scoreboard, arbiter pointer and sticky error state
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q <= '0;
      pri_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      busy_q <= busy_d;
      pri_q  <= pri_d;
      if (spur)
        err_q <= 1'b1;
    end
  end

  // Registered register-file write port; address/data hold when idle
  always_ff @(posedge clk) begin
    if (!rst) begin
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      rf_wen_q <= xfer && (x_rd != 5'd0);
      if (xfer) begin
        rf_waddr_q <= x_rd;
        rf_wdata_q <= x_data;
      end
    end
  end

  assign rf_wen       = rf_wen_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign err_spurious = err_q;

`ifdef REGWB_FWD_EN
  logic hit1, hit2;

  // A source matching the in-flight write is served from the port
  always_comb begin
    hit1 = rf_wen_q && (rs1 == rf_waddr_q) && (rs1 != 5'd0);
    hit2 = rf_wen_q && (rs2 == rf_waddr_q) && (rs2 != 5'd0);
    rs1_busy     = busy_q[rs1] && !hit1;
    rs2_busy     = busy_q[rs2] && !hit2;
    rs1_fwd      = hit1;
    rs2_fwd      = hit2;
    rs1_fwd_data = rf_wdata_q;
    rs2_fwd_data = rf_wdata_q;
  end
`else
  assign rs1_busy = busy_q[rs1];
  assign rs2_busy = busy_q[rs2];
`endif

endmodule
